demux_rr_sched_v: RTL and testbench

//   Round-robin scheduler for the 1-to-4 demux datapath: takes one source stream (valid/ready)
//   and distributes it in bursts across four destinations. Drives the demux one-hot select code,
//   a registered data copy and per-destination one-hot strobes. Sits between the source and the

---
 rtl/demux_rr_sched_v.sv | 159 +++++++++++++++
 tb/tb_demux_rr_sched_v.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched_v.sv
// ============================================================================
//  Module   : demux_rr_sched_v
//  Brief    : Round-robin burst scheduler feeding a 1:4 demux (valid/ready in,
//             one-hot select, registered data copy, per-destination strobes).
//             Optional build macro RR_SKIP_BUSY_EN skips destinations whose
//             ready is low when picking the next grant.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_rr_sched_v #(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_dst_ready,
    output logic [3:0]        o_sel_code,
    output logic [DATA_W-1:0] o_data,
    output logic [3:0]        o_valid,
    output logic              o_busy
);

    localparam int                c_cnt_w  = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BURST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [3:0]          sel_code_q, sel_code_d;
    logic [3:0]          valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    logic                w_xfer;
    logic [1:0]          w_cand;
    logic                w_cand_found;

    assign o_ready    = (state_q == XFER) & i_dst_ready[grant_q] & i_en;
    assign w_xfer     = i_valid & o_ready;
    assign o_sel_code = sel_code_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

`ifdef RR_SKIP_BUSY_EN
    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        w_cand       = ptr_q;
        w_cand_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (i_dst_ready[ptr_q + 2'(k)]) begin
                w_cand       = ptr_q + 2'(k);
                w_cand_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_cand       = ptr_q;
        w_cand_found = 1'b1;
    end
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        sel_code_d = sel_code_q;
        busy_d     = busy_q;
        data_d     = data_q;
        valid_d    = 4'b0000;

        if (w_xfer) begin
            data_d  = i_data;
            valid_d = 4'b0001 << grant_q;
        end

        case (state_q)
            IDLE: begin
                if (i_en) state_d = SEL;
            end
            SEL: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (w_cand_found) begin
                    state_d    = XFER;
                    grant_d    = w_cand;
                    cnt_d      = '0;
                    sel_code_d = 4'b0001 << w_cand;
                    busy_d     = 1'b1;
                end
            end
            XFER: begin
                // A disabled partial burst still hands the turn to the next destination.
                if (!i_en) begin
                    state_d    = IDLE;
                    ptr_d      = grant_q + 2'd1;
                    cnt_d      = '0;
                    sel_code_d = 4'b0000;
                    busy_d     = 1'b0;
                end else if (w_xfer) begin
                    if (cnt_q == c_cnt_last) begin
                        state_d    = SEL;
                        ptr_d      = grant_q + 2'd1;
                        cnt_d      = '0;
                        sel_code_d = 4'b0000;
                        busy_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                sel_code_d = 4'b0000;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            grant_q    <= 2'd0;
            cnt_q      <= '0;
            sel_code_q <= 4'b0000;
            valid_q    <= 4'b0000;
            data_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            sel_code_q <= sel_code_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_sched_v.sv
// ============================================================================
//  Module   : tb_demux_rr_sched_v
//  Brief    : Directed self-checking bench for demux_rr_sched_v (BURST_LEN=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_rr_sched_v;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       valid;
    logic       ready;
    logic [0:0] data;
    logic [3:0] dst_ready;
    logic [3:0] sel_code;
    logic [0:0] odata;
    logic [3:0] ovalid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    demux_rr_sched_v #(.DATA_W(1), .BURST_LEN(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_data      (data),
        .i_dst_ready (dst_ready),
        .o_sel_code  (sel_code),
        .o_data      (odata),
        .o_valid     (ovalid),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        valid     = 1'b0;
        dst_ready = 4'b0000;
        data      = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   32'(sel_code), 32'h0);
        chk({tag, "_valid"}, 32'(ovalid),   32'h0);
        chk({tag, "_data"},  32'(odata),    32'h0);
        chk({tag, "_busy"},  32'(busy),     32'h0);
        chk({tag, "_ready"}, 32'(ready),    32'h0);
    endtask

    initial begin
        int         cnt0;
        logic [3:0] exp_v;

        // Power-on reset
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; dst_ready = 4'b0; data = 1'b0;
        #1;
        chk_all_zero("por");
        do_reset();

        // Rotation over all four destinations and wrap back to 0
        en = 1'b1; valid = 1'b1; dst_ready = 4'b1111; data = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (i < 3)                exp_v = 4'b0000;
            else if ((i - 3) % 5 == 4) exp_v = 4'b0000;
            else                      exp_v = 4'b0001 << (((i - 3) / 5) % 4);
            chk($sformatf("rot_valid_e%0d", i), 32'(ovalid), 32'(exp_v));
            if (i == 2)  chk("rot_sel_e2",  32'(sel_code), 32'h1);
            if (i == 6)  chk("rot_sel_e6",  32'(sel_code), 32'h0);
            if (i == 17) chk("rot_sel_e17", 32'(sel_code), 32'h8);
        end

        // Asynchronous reset in the middle of a burst
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        en = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chk("midrst_idle_busy", 32'(busy),     32'h0);
        chk("midrst_idle_sel",  32'(sel_code), 32'h0);

        // Backpressure on destination 0 for three cycles
        do_reset();
        en = 1'b1; valid = 1'b1; dst_ready = 4'b1111;
        cnt0 = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ovalid == 4'b0001) cnt0++;
            if (i == 4) dst_ready = 4'b1110;
            if (i == 7) dst_ready = 4'b1111;
            #1;
            if (i >= 4 && i <= 6) chk($sformatf("bp_ready_e%0d", i), 32'(ready), 32'h0);
            if (i == 5) chk("bp_sel_held", 32'(sel_code), 32'h1);
            if (i == 9) chk("bp_sel_e9",   32'(sel_code), 32'h0);
            if (i == 10) chk("bp_sel_e10", 32'(sel_code), 32'h2);
        end
        chk("bp_strobes_dst0", 32'(cnt0), 32'd4);

        // Enable drop after two beats to destination 1
        do_reset();
        en = 1'b1; valid = 1'b1; dst_ready = 4'b1111;
        repeat (9) tick();
        chk("en_beat2_valid", 32'(ovalid), 32'h2);
        en = 1'b0;
        #1;
        chk("en_drop_ready", 32'(ready), 32'h0);
        tick();
        chk("en_idle_valid", 32'(ovalid),   32'h0);
        chk("en_idle_sel",   32'(sel_code), 32'h0);
        chk("en_idle_busy",  32'(busy),     32'h0);
        en = 1'b1;
        tick();
        tick();
        chk("en_next_grant", 32'(sel_code), 32'h4);
        tick();
        chk("en_next_valid", 32'(ovalid), 32'h4);

        // ptr=1 with only destinations 0 and 3 ready
        do_reset();
        en = 1'b1; valid = 1'b1; dst_ready = 4'b1111;
        repeat (5) tick();
        dst_ready = 4'b1001;
        tick();
        tick();
`ifdef RR_SKIP_BUSY_EN
        chk("skip_grant", 32'(sel_code), 32'h8);
        chk("skip_ready", 32'(ready),    32'h1);
`else
        chk("strict_grant", 32'(sel_code), 32'h2);
        chk("strict_ready", 32'(ready),    32'h0);
        tick();
        chk("strict_stall_valid", 32'(ovalid), 32'h0);
`endif

        // No destination ready at all
        do_reset();
        en = 1'b1; valid = 1'b1; dst_ready = 4'b0000;
        tick();
        tick();
`ifdef RR_SKIP_BUSY_EN
        chk("none_sel",  32'(sel_code), 32'h0);
        chk("none_busy", 32'(busy),     32'h0);
`else
        chk("none_sel",  32'(sel_code), 32'h1);
        chk("none_busy", 32'(busy),     32'h1);
`endif
        chk("none_ready", 32'(ready), 32'h0);

        // Data path latency of one cycle
        do_reset();
        en = 1'b1; valid = 1'b0; dst_ready = 4'b1111; data = 1'b0;
        tick();
        tick();
        valid = 1'b1; data = 1'b1;
        #1;
        chk("dp_ready", 32'(ready), 32'h1);
        tick();
        chk("dp_data_t1",  32'(odata),  32'h1);
        chk("dp_valid_t1", 32'(ovalid), 32'h1);
        valid = 1'b0; data = 1'b0;
        tick();
        chk("dp_valid_t2", 32'(ovalid), 32'h0);
        chk("dp_data_hold", 32'(odata), 32'h1);
        valid = 1'b1;
        tick();
        chk("dp_data_zero", 32'(odata),  32'h0);
        chk("dp_valid_t4",  32'(ovalid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
